countdown_timer_n: RTL and testbench
====================================

# countdown_timer_n

- Parametrised HH:MM:SS timer on a single system clock.
- Editing uses a digit cursor (left/right) and up/down buttons with carry and borrow between fields.
- Runs in countdown or count-up mode, supports pause/resume and soft clear, and flags expiry.
- Sits between the debounced button front-end and the seven-segment display driver. Counting is paced by a 1 Hz `tick_i` enable, not by a slow clock.

## Interface
- `HOUR_MAX`, 99: maximum hours value; upper saturation bound is HOUR_MAX:59:59.
- `HOUR_W`, 7: hour field width; must satisfy 2^HOUR_W > HOUR_MAX.
- `DEF_HOUR`, 0: preset hours loaded on reset.
- `DEF_MIN`, 5: preset minutes loaded on reset.
- `DEF_SEC`, 0: preset seconds loaded on reset.
- `DEF_DIGIT`, 3: cursor position loaded on reset.
- `clk_i`  in  1  system clock; the only clock.
- `reset_i`  in  1  asynchronous, active-low reset.
- `tick_i`  in  1  one-cycle 1 Hz count enable.
- `start_i`  in  1  level; rising edge means start/pause/resume.
- `clear_i`  in  1  level; rising edge means abort and return to edit.
- `mode_i`  in  1  0 = countdown, 1 = count-up; sampled on leaving IDLE.
- `left_i`, `right_i`, `up_i`, `down_i`  in  1 each  debounced, synchronous button levels.
- `hour_o`  out  HOUR_W  displayed hours.
- `min_o`  out  6  displayed minutes.
- `sec_o`  out  6  displayed seconds.
- `digitp_o`  out  3  cursor position, 0..5 = H10, H1, M10, M1, S10, S1.
- `running_o`  out  1  high in RUN.
- `expired_o`  out  1  high in DONE.
- `done_o`  out  1  one-cycle pulse when the target is reached.

## Operation
- Every control and button input is edge-detected internally; only the rising edge acts.
- Edge history updates in all states, so a press made outside IDLE never fires later.
- States are IDLE (edit), RUN, PAUSE and DONE.
- In IDLE, the display mirrors the preset registers.
- Cursor:
  - left decrements `digitp_o`, saturating at 0.
  - right increments it, saturating at 5.
- Up/down add or subtract the cursor weight: 10 h, 1 h, 10 min, 1 min, 10 s, 1 s.
  - Field overflow carries into the next higher field (e.g. 00:55:00 +10 min → 01:05:00).
  - Field underflow borrows from the next higher field (00:05:00 −10 min → invalid, see saturation).
- Saturation:
  - A result above HOUR_MAX:59:59 becomes HOUR_MAX:59:59.
  - A result below 00:00:00 leaves the preset unchanged.
- Button edges arriving in the same cycle: only the highest-priority one acts, in the order left, right, up, down.
- IDLE → RUN on a start edge, with `mode_i` latched.
  - Countdown: display = preset. The start is ignored if the preset is 00:00:00.
  - Count-up: display = 00:00:00. The start is ignored if the preset is 00:00:00.
- RUN, on `tick_i`:
  - Countdown: decrement with borrow (s 0 → 59 borrowing from min; min 0 → 59 borrowing from hour).
  - Count-up: increment with carry.
- Target reached (countdown hits 00:00:00, count-up equals preset): `done_o` pulses and the state goes to DONE, with the display frozen.
- RUN → PAUSE on a start edge. PAUSE → RUN on a start edge. Ticks are ignored in PAUSE.
- DONE → IDLE on a start or clear edge.
- Clear edge in RUN or PAUSE → IDLE.
- Preset is never modified outside IDLE.
- Clear edge and start edge in the same cycle: clear wins.

## Timing
- Reset (`reset_i` low): state IDLE; preset and display = DEF_HOUR:DEF_MIN:DEF_SEC; `digitp_o` = DEF_DIGIT; `running_o`, `expired_o` and `done_o` all 0.
- All outputs are registered.
- A button edge sampled at clock edge n is visible on the outputs after edge n+1.
- A start edge sampled at edge n puts the block in RUN after edge n+1. A `tick_i` in that same cycle is ignored.
- A tick sampled at edge n updates the display after edge n+1.
- `done_o` and `expired_o` assert on the same edge that the display reaches the target.
- A tick coinciding with a start edge (pause) in RUN: the pause takes effect and the tick is dropped.
- A tick coinciding with a clear edge: the clear takes effect and the tick is dropped.

## Configuration
- Macro: `COUNTDOWN_TIMER_AUTORELOAD_EN`.
- Defined: on reaching the target, `done_o` pulses, the display reloads (countdown: preset; count-up: 00:00:00) on the same edge, and the block stays in RUN. DONE is unreachable and `expired_o` stays 0.
- Undefined: the block enters DONE as described under Operation.

## Structure
- Package `timer_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - digit-position constants DIG_H10 … DIG_S1;
  - the constants SEC_MAX = 59 and MIN_MAX = 59.
- Sub-module `btn_edge`: a parametrised-width rising-edge detector with asynchronous active-low reset. It is instantiated once for all seven control inputs.

## Test plan
- Reset, then up at DEF_DIGIT = 3 twice → display 00:07:00. Left ×5 → `digitp_o` = 0 (saturated).
- Preset 00:58:00, cursor 2, up → 01:08:00. Preset 99:59:59, cursor 5, up → unchanged. Preset 00:00:05, cursor 4, down → unchanged.
- Preset 00:01:02, countdown, start, 62 ticks → 00:00:00 with `done_o` high for one cycle and `expired_o` = 1. A further tick leaves the display at 00:00:00.
- Count-up, preset 00:00:03: start, 3 ticks → display 00:00:03 and `done_o` pulses. With `COUNTDOWN_TIMER_AUTORELOAD_EN` defined, display 00:00:00 and `running_o` still 1.
- During RUN: start edge → PAUSE, 5 ticks with no display change. Start → RUN. Up presses in RUN/PAUSE leave the preset unchanged.
- Assert `reset_i` low mid-RUN → immediate return to DEF values and IDLE. Simultaneous clear and start edges in RUN → IDLE showing the preset.

Source files
------------

// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg
// Shared states, cursor digit positions and field limits for countdown_timer_n.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] DIG_H10 = 3'd0;
  localparam logic [2:0] DIG_H1  = 3'd1;
  localparam logic [2:0] DIG_M10 = 3'd2;
  localparam logic [2:0] DIG_M1  = 3'd3;
  localparam logic [2:0] DIG_S10 = 3'd4;
  localparam logic [2:0] DIG_S1  = 3'd5;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

`default_nettype wire

// File: rtl/btn_edge.sv
// ============================================================================
// btn_edge
// Registered rising-edge detector for a vector of synchronous level inputs.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      rise <= '0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
    end
  end

endmodule

`default_nettype wire

// File: rtl/countdown_timer_n.sv
// ============================================================================
// countdown_timer_n
// HH:MM:SS edit/countdown/count-up timer paced by a 1 Hz tick enable.
// Optional feature macro: COUNTDOWN_TIMER_AUTORELOAD_EN (reload instead of DONE).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer_n
  import timer_pkg::*;
#(
  parameter int HOUR_MAX  = 99,
  parameter int HOUR_W    = 7,
  parameter int DEF_HOUR  = 0,
  parameter int DEF_MIN   = 5,
  parameter int DEF_SEC   = 0,
  parameter int DEF_DIGIT = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              tick_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              mode_i,
  input  logic              left_i,
  input  logic              right_i,
  input  logic              up_i,
  input  logic              down_i,
  output logic [HOUR_W-1:0] hour_o,
  output logic [5:0]        min_o,
  output logic [5:0]        sec_o,
  output logic [2:0]        digitp_o,
  output logic              running_o,
  output logic              expired_o,
  output logic              done_o
);

  logic [6:0] rise;
  logic tick_e, start_e, clear_e, left_e, right_e, up_e, down_e;

  btn_edge #(.WIDTH(7)) u_edge (
    .clk   (clk_i),
    .rst_n (reset_i),
    .level ({down_i, up_i, right_i, left_i, clear_i, start_i, tick_i}),
    .rise  (rise)
  );

  assign {down_e, up_e, right_e, left_e, clear_e, start_e, tick_e} = rise;

  state_t state, state_nxt;
  logic [HOUR_W-1:0] pre_hour, pre_hour_nxt, hour_nxt, edit_hour, tk_hour;
  logic [5:0] pre_min, pre_min_nxt, min_nxt, edit_min, tk_min;
  logic [5:0] pre_sec, pre_sec_nxt, sec_nxt, edit_sec, tk_sec;
  logic [2:0] digit_nxt;
  logic mode_up, mode_nxt, done_nxt, running_nxt, expired_nxt;
  logic preset_nz, target_hit;
  int h_t, m_t, s_t, dir;

  assign preset_nz = |{pre_hour, pre_min, pre_sec};

  // Edited preset: apply cursor weight, then one carry/borrow pass per field.
  always_comb begin
    dir = up_e ? 1 : -1;
    h_t = int'(pre_hour);
    m_t = int'(pre_min);
    s_t = int'(pre_sec);
    case (digitp_o)
      DIG_H10: h_t = h_t + 10 * dir;
      DIG_H1:  h_t = h_t + dir;
      DIG_M10: m_t = m_t + 10 * dir;
      DIG_M1:  m_t = m_t + dir;
      DIG_S10: s_t = s_t + 10 * dir;
      default: s_t = s_t + dir;
    endcase
    if (s_t > int'(SEC_MAX)) begin
      s_t = s_t - 60;
      m_t = m_t + 1;
    end else if (s_t < 0) begin
      s_t = s_t + 60;
      m_t = m_t - 1;
    end
    if (m_t > int'(MIN_MAX)) begin
      m_t = m_t - 60;
      h_t = h_t + 1;
    end else if (m_t < 0) begin
      m_t = m_t + 60;
      h_t = h_t - 1;
    end
    if (h_t > HOUR_MAX) begin
      edit_hour = HOUR_W'(HOUR_MAX);
      edit_min  = MIN_MAX;
      edit_sec  = SEC_MAX;
    end else if (h_t < 0) begin
      edit_hour = pre_hour;
      edit_min  = pre_min;
      edit_sec  = pre_sec;
    end else begin
      edit_hour = HOUR_W'(h_t);
      edit_min  = 6'(m_t);
      edit_sec  = 6'(s_t);
    end
  end

  always_comb begin
    tk_hour = hour_o;
    tk_min  = min_o;
    tk_sec  = sec_o;
    if (mode_up) begin
      if (sec_o == SEC_MAX) begin
        tk_sec = '0;
        if (min_o == MIN_MAX) begin
          tk_min  = '0;
          tk_hour = hour_o + 1'b1;
        end else begin
          tk_min = min_o + 6'd1;
        end
      end else begin
        tk_sec = sec_o + 6'd1;
      end
    end else begin
      if (sec_o == '0) begin
        tk_sec = SEC_MAX;
        if (min_o == '0) begin
          tk_min  = MIN_MAX;
          tk_hour = hour_o - 1'b1;
        end else begin
          tk_min = min_o - 6'd1;
        end
      end else begin
        tk_sec = sec_o - 6'd1;
      end
    end
    target_hit = mode_up ? ({tk_hour, tk_min, tk_sec} == {pre_hour, pre_min, pre_sec})
                         : ({tk_hour, tk_min, tk_sec} == '0);
  end

  // Next-state and datapath; clear outranks start, which outranks tick.
  always_comb begin
    state_nxt    = state;
    pre_hour_nxt = pre_hour;
    pre_min_nxt  = pre_min;
    pre_sec_nxt  = pre_sec;
    hour_nxt     = hour_o;
    min_nxt      = min_o;
    sec_nxt      = sec_o;
    digit_nxt    = digitp_o;
    mode_nxt     = mode_up;
    done_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_e) begin
          state_nxt = ST_IDLE;
        end else if (start_e && preset_nz) begin
          state_nxt = ST_RUN;
          mode_nxt  = mode_i;
        end else if (left_e) begin
          if (digitp_o != DIG_H10) digit_nxt = digitp_o - 3'd1;
        end else if (right_e) begin
          if (digitp_o != DIG_S1) digit_nxt = digitp_o + 3'd1;
        end else if (up_e || down_e) begin
          pre_hour_nxt = edit_hour;
          pre_min_nxt  = edit_min;
          pre_sec_nxt  = edit_sec;
        end
        if (state_nxt == ST_RUN && mode_i) begin
          hour_nxt = '0;
          min_nxt  = '0;
          sec_nxt  = '0;
        end else begin
          hour_nxt = pre_hour_nxt;
          min_nxt  = pre_min_nxt;
          sec_nxt  = pre_sec_nxt;
        end
      end
      ST_RUN: begin
        if (clear_e) begin
          state_nxt = ST_IDLE;
        end else if (start_e) begin
          state_nxt = ST_PAUSE;
        end else if (tick_e) begin
          hour_nxt = tk_hour;
          min_nxt  = tk_min;
          sec_nxt  = tk_sec;
          if (target_hit) begin
            done_nxt = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            hour_nxt = mode_up ? '0 : pre_hour;
            min_nxt  = mode_up ? '0 : pre_min;
            sec_nxt  = mode_up ? '0 : pre_sec;
`else
            state_nxt = ST_DONE;
`endif
          end
        end
      end
      ST_PAUSE: begin
        if (clear_e)      state_nxt = ST_IDLE;
        else if (start_e) state_nxt = ST_RUN;
      end
      default: begin
        if (clear_e || start_e) state_nxt = ST_IDLE;
      end
    endcase
    if (state != ST_IDLE && state_nxt == ST_IDLE) begin
      hour_nxt = pre_hour;
      min_nxt  = pre_min;
      sec_nxt  = pre_sec;
    end
  end

  always_comb begin
    running_nxt = (state_nxt == ST_RUN);
    expired_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= ST_IDLE;
      pre_hour  <= HOUR_W'(DEF_HOUR);
      pre_min   <= 6'(DEF_MIN);
      pre_sec   <= 6'(DEF_SEC);
      hour_o    <= HOUR_W'(DEF_HOUR);
      min_o     <= 6'(DEF_MIN);
      sec_o     <= 6'(DEF_SEC);
      digitp_o  <= 3'(DEF_DIGIT);
      mode_up   <= 1'b0;
      done_o    <= 1'b0;
      running_o <= 1'b0;
      expired_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre_hour  <= pre_hour_nxt;
      pre_min   <= pre_min_nxt;
      pre_sec   <= pre_sec_nxt;
      hour_o    <= hour_nxt;
      min_o     <= min_nxt;
      sec_o     <= sec_nxt;
      digitp_o  <= digit_nxt;
      mode_up   <= mode_nxt;
      done_o    <= done_nxt;
      running_o <= running_nxt;
      expired_o <= expired_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_n.sv
// ============================================================================
// tb_countdown_timer_n
// Directed self-checking bench for countdown_timer_n (default parameters).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer_n;

  localparam int B_TICK  = 0;
  localparam int B_START = 1;
  localparam int B_CLEAR = 2;
  localparam int B_LEFT  = 3;
  localparam int B_RIGHT = 4;
  localparam int B_UP    = 5;
  localparam int B_DOWN  = 6;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       mode_i;
  logic [6:0] btn;
  logic [6:0] hour_o;
  logic [5:0] min_o;
  logic [5:0] sec_o;
  logic [2:0] digitp_o;
  logic       running_o;
  logic       expired_o;
  logic       done_o;

  int n_cmp = 0;
  int n_bad = 0;

  countdown_timer_n dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .tick_i    (btn[B_TICK]),
    .start_i   (btn[B_START]),
    .clear_i   (btn[B_CLEAR]),
    .mode_i    (mode_i),
    .left_i    (btn[B_LEFT]),
    .right_i   (btn[B_RIGHT]),
    .up_i      (btn[B_UP]),
    .down_i    (btn[B_DOWN]),
    .hour_o    (hour_o),
    .min_o     (min_o),
    .sec_o     (sec_o),
    .digitp_o  (digitp_o),
    .running_o (running_o),
    .expired_o (expired_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hms(input int h, input int m, input int s);
    return 32'(h * 10000 + m * 100 + s);
  endfunction

  function automatic logic [31:0] disp();
    return hms(int'(hour_o), int'(min_o), int'(sec_o));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle pulse on the selected inputs; returns once the timer has acted on it.
  task automatic press_mask(input logic [6:0] m);
    btn = m;
    @(posedge clk); #1;
    btn = '0;
    @(posedge clk); #1;
  endtask

  task automatic press(input int b, input int n = 1);
    for (int i = 0; i < n; i++) press_mask(7'(1 << b));
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    btn     = '0;
    mode_i  = 1'b0;
    reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_disp", disp(), hms(0, 5, 0));
    check("rst_digit", 32'(digitp_o), 32'd3);
    check("rst_flags", {29'd0, running_o, expired_o, done_o}, 32'd0);
    reset_i = 1'b1;
    @(posedge clk); #1;

    press(B_UP, 2);
    check("up_m1_x2", disp(), hms(0, 7, 0));
    press(B_LEFT, 5);
    check("left_sat", 32'(digitp_o), 32'd0);

    press(B_RIGHT, 2);
    press(B_UP, 5);
    press(B_RIGHT);
    press(B_UP);
    check("preset_58", disp(), hms(0, 58, 0));
    press(B_LEFT);
    press(B_UP);
    check("carry_min_hr", disp(), hms(1, 8, 0));

    press(B_LEFT, 2);
    press(B_UP, 9);
    check("h10_x9", disp(), hms(91, 8, 0));
    press(B_UP);
    check("sat_high", disp(), hms(99, 59, 59));
    press(B_RIGHT, 5);
    check("right_sat", 32'(digitp_o), 32'd5);
    press(B_UP);
    check("sat_keep", disp(), hms(99, 59, 59));

    do_reset();
    press(B_DOWN, 5);
    check("down_to_zero", disp(), hms(0, 0, 0));
    press(B_START);
    check("start_zero_ign", 32'(running_o), 32'd0);
    press(B_RIGHT, 2);
    press(B_UP, 5);
    press(B_LEFT);
    press(B_DOWN);
    check("underflow_keep", disp(), hms(0, 0, 5));

    press(B_LEFT);
    press(B_UP);
    press(B_RIGHT, 2);
    press(B_DOWN, 3);
    check("preset_0102", disp(), hms(0, 1, 2));
    mode_i = 1'b0;
    press(B_START);
    check("cd_running", 32'(running_o), 32'd1);
    check("cd_start_disp", disp(), hms(0, 1, 2));
    press(B_TICK, 61);
    check("cd_61", disp(), hms(0, 0, 1));
    check("cd_61_done", 32'(done_o), 32'd0);
    press(B_TICK);
    check("cd_zero", disp(), hms(0, 0, 0));
    check("cd_done", 32'(done_o), 32'd1);
    check("cd_expired", 32'(expired_o), 32'd1);
    @(posedge clk); #1;
    check("cd_done_1cyc", 32'(done_o), 32'd0);
    press(B_TICK);
    check("cd_frozen", disp(), hms(0, 0, 0));
    press(B_START);
    check("done_to_idle", disp(), hms(0, 1, 2));
    check("done_exp_clr", 32'(expired_o), 32'd0);

    press(B_LEFT, 2);
    press(B_DOWN);
    press(B_RIGHT, 2);
    press(B_UP);
    check("preset_0003", disp(), hms(0, 0, 3));
    mode_i = 1'b1;
    press(B_START);
    check("cu_start", disp(), hms(0, 0, 0));
    press(B_TICK, 2);
    check("cu_2", disp(), hms(0, 0, 2));
    press(B_TICK);
    check("cu_done", 32'(done_o), 32'd1);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    check("cu_reload", disp(), hms(0, 0, 0));
    check("cu_running", 32'(running_o), 32'd1);
    check("cu_noexp", 32'(expired_o), 32'd0);
`else
    check("cu_target", disp(), hms(0, 0, 3));
    check("cu_expired", 32'(expired_o), 32'd1);
`endif
    press(B_CLEAR);
    check("cu_clear", 32'(running_o), 32'd0);

    mode_i = 1'b0;
    press(B_START);
    press(B_TICK);
    check("run_tick", disp(), hms(0, 0, 2));
    press(B_START);
    check("pause_flag", 32'(running_o), 32'd0);
    press(B_TICK, 5);
    check("pause_hold", disp(), hms(0, 0, 2));
    press(B_UP);
    press(B_START);
    check("resume", 32'(running_o), 32'd1);
    press(B_UP);
    press(B_TICK);
    check("resume_tick", disp(), hms(0, 0, 1));
    press(B_CLEAR);
    check("preset_kept", disp(), hms(0, 0, 3));

    press(B_START);
    press_mask(7'((1 << B_TICK) | (1 << B_START)));
    check("tick_pause_st", 32'(running_o), 32'd0);
    check("tick_pause_disp", disp(), hms(0, 0, 3));
    press(B_CLEAR);
    press(B_START);
    press_mask(7'((1 << B_CLEAR) | (1 << B_START)));
    check("clr_start_st", {30'd0, running_o, expired_o}, 32'd0);
    check("clr_start_disp", disp(), hms(0, 0, 3));

    press(B_START);
    press(B_TICK);
    reset_i = 1'b0;
    #1;
    check("async_rst_disp", disp(), hms(0, 5, 0));
    check("async_rst_dig", 32'(digitp_o), 32'd3);
    check("async_rst_run", 32'(running_o), 32'd0);
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
